riscv_multicycle_core: RTL

RISCV_MULTICYCLE_CORE -- requirements
Module: riscv_multicycle_core

---
 rtl/riscv_multicycle_core.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_core.sv
// rtl/riscv_multicycle_core.sv - multi-cycle RV32I-subset core sharing one memory port for fetch and data
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          NUM_REGS         = 32,
  parameter bit          HALT_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_dbg
);
  localparam int RW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nxt;

  logic [31:0] pc, ir, a, b, imm, res;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        is_r, is_i, is_lui, is_lw, is_sw, is_br, is_jal, is_alu, legal;
  logic        use_rd, use_rs1, use_rs2;
  logic        misalign_trap, taken, ctl_trap;
  logic [31:0] imm_dec, alu_out, ea, ea_word, br_tgt;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  function automatic logic idx_ok(input logic [4:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  function automatic logic [31:0] rf_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : regs[idx[RW-1:0]];
  endfunction

  always_comb begin
    is_r    = (opcode == 7'b0110011) &&
              (((f7 == 7'b0000000) && (f3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010})) ||
               ((f7 == 7'b0100000) && (f3 == 3'b000)));
    is_i    = (opcode == 7'b0010011) && (f3 inside {3'b000, 3'b111, 3'b110});
    is_lui  = (opcode == 7'b0110111);
    is_lw   = (opcode == 7'b0000011) && (f3 == 3'b010);
    is_sw   = (opcode == 7'b0100011) && (f3 == 3'b010);
    is_br   = (opcode == 7'b1100011) && (f3[2:1] == 2'b00);
    is_jal  = (opcode == 7'b1101111);
    is_alu  = is_r || is_i || is_lui;
    use_rd  = is_alu || is_lw || is_jal;
    use_rs1 = is_r || is_i || is_lw || is_sw || is_br;
    use_rs2 = is_r || is_sw || is_br;
    legal   = (is_alu || is_lw || is_sw || is_br || is_jal) &&
              (!use_rd || idx_ok(rd)) && (!use_rs1 || idx_ok(rs1)) && (!use_rs2 || idx_ok(rs2));

    if (is_sw)       imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_br)  imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    else if (is_jal) imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    else if (is_lui) imm_dec = {ir[31:12], 12'd0};
    else             imm_dec = {{20{ir[31]}}, ir[31:20]};
  end

  always_comb begin
    alu_out = 32'd0;
    if (is_lui) begin
      alu_out = imm;
    end else if (is_i) begin
      case (f3)
        3'b111:  alu_out = a & imm;
        3'b110:  alu_out = a | imm;
        default: alu_out = a + imm;
      endcase
    end else if (is_r) begin
      case (f3)
        3'b111:  alu_out = a & b;
        3'b110:  alu_out = a | b;
        3'b100:  alu_out = a ^ b;
        3'b010:  alu_out = {31'd0, $signed(a) < $signed(b)};
        default: alu_out = f7[5] ? (a - b) : (a + b);
      endcase
    end
  end

  // Without the misalign trap the low address bits are simply dropped.
  assign ea            = a + imm;
  assign ea_word       = {ea[31:2], 2'b00};
  assign misalign_trap = HALT_ON_MISALIGN && (ea[1:0] != 2'b00);
  assign taken         = is_jal || (is_br && ((a == b) ^ f3[0]));
  assign br_tgt        = pc + imm;
  assign ctl_trap      = taken && (br_tgt[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (mem_ready) state_nxt = DECODE;
      DECODE:  state_nxt = legal ? EXEC : HALT;
      EXEC: begin
        if (is_lw || is_sw)       state_nxt = misalign_trap ? HALT : MEM;
        else if (is_br || is_jal) state_nxt = ctl_trap ? HALT : FETCH;
        else                      state_nxt = WB;
      end
      MEM:     if (mem_ready) state_nxt = is_lw ? WB : FETCH;
      WB:      state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end

  // Gating with rst lets an asserted reset drop the request without waiting for a clock.
  always_comb begin
    mem_valid = rst && ((state == FETCH) || (state == MEM));
    mem_we    = rst && (state == MEM) && is_sw;
    retire    = (state == WB) ||
                ((state == EXEC) && (is_br || is_jal) && !ctl_trap) ||
                ((state == MEM) && is_sw && mem_ready);
    halted    = (state == HALT);
  end

  assign mem_addr  = (state == MEM) ? res : pc;
  assign mem_wdata = b;
  assign pc_dbg    = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= RESET_PC;
      ir  <= 32'd0;
      a   <= 32'd0;
      b   <= 32'd0;
      imm <= 32'd0;
      res <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else begin
      case (state)
        FETCH: if (mem_ready) ir <= mem_rdata;
        DECODE: begin
          a   <= rf_rd(rs1);
          b   <= rf_rd(rs2);
          imm <= imm_dec;
        end
        EXEC: begin
          if (is_lw || is_sw) begin
            res <= ea_word;
          end else if (is_alu) begin
            res <= alu_out;
          end else if (!ctl_trap) begin
            pc <= taken ? br_tgt : pc + 32'd4;
            if (is_jal && (rd != 5'd0)) regs[rd[RW-1:0]] <= pc + 32'd4;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (is_lw) res <= mem_rdata;
            else       pc  <= pc + 32'd4;
          end
        end
        WB: begin
          if (rd != 5'd0) regs[rd[RW-1:0]] <= res;
          pc <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end
endmodule
